lsu_bus_bridge: RTL and testbench

- Load/store unit directly downstream of the core's execute stage; replaces the core's direct data-memory connection.
- Takes the core's ALU-computed address, store data and funct3, and performs the access on a valid/ready data bus.
- Returns aligned, sign- or zero-extended load data for writeback.
- Stalls the core (PC and register-file write held) until the access completes.

---
 rtl/lsu_bus_bridge.sv | 193 +++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core's execute stage and a valid/ready data bus.
// Decodes funct3 into byte enables and lane-replicated store data, flags
// misaligned or illegal accesses without touching the bus, runs one bus
// request/response per instruction under a timeout, and returns extended load
// data. The core is stalled until the single-cycle DONE state.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  input  logic        bus_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  // Counter value seen in the last cycle allowed in REQ+RSP.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt;
  logic        misalign_q;
  logic        err_q;

  logic        dec_illegal;
  logic        dec_misalign;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic [31:0] load_ext;
  logic [31:0] rsp_shifted;
  logic        tmo;

  assign tmo = (cnt >= TMO_LAST);

  // Decode the incoming request: legality, alignment, byte enables, store lanes.
  always_comb begin
    // NOTE: every signal gets a default before the case, otherwise the
    // unassigned branches would infer latches.
    dec_be       = 4'b0000;
    dec_wdata    = req_wdata;
    dec_misalign = 1'b0;
    if (req_we) dec_illegal = (req_func3 > 3'b010);
    else        dec_illegal = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11);
    case (req_func3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << req_addr[1:0];
        dec_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        dec_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{req_wdata[15:0]}};
        dec_misalign = req_addr[0];
      end
      2'b10: begin
        dec_be       = 4'b1111;
        dec_misalign = (req_addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // Select the addressed byte/half of the response word and extend it.
  always_comb begin
    rsp_shifted = bus_rsp_data >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'b000:  load_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_ext = addr_q[1] ? {{16{bus_rsp_data[31]}}, bus_rsp_data[31:16]}
                                    : {{16{bus_rsp_data[15]}}, bus_rsp_data[15:0]};
      3'b100:  load_ext = {24'h0, rsp_shifted[7:0]};
      3'b101:  load_ext = addr_q[1] ? {16'h0, bus_rsp_data[31:16]}
                                    : {16'h0, bus_rsp_data[15:0]};
      default: load_ext = bus_rsp_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a bus handshake or response takes priority over timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = (dec_illegal || dec_misalign) ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus_req_ready) state_next = S_RSP;
        else if (tmo)      state_next = S_DONE;
      end
      S_RSP:  if (bus_rsp_valid || tmo) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counter, completion flags and load data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      func3_q    <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            addr_q     <= req_addr;
            we_q       <= req_we;
            func3_q    <= req_func3;
            be_q       <= dec_be;
            wdata_q    <= dec_wdata;
            err_q      <= dec_illegal;
            misalign_q <= dec_misalign && !dec_illegal;
          end
        end
        S_REQ: begin
          cnt <= cnt + 16'd1;
          if (!bus_req_ready && tmo) begin
            err_q <= 1'b1;
            if (!we_q) rdata <= '0;
          end
        end
        S_RSP: begin
          cnt <= cnt + 16'd1;
          if (bus_rsp_valid) begin
            if (bus_rsp_err) begin
              err_q <= 1'b1;
              rdata <= '0;
            end else if (!we_q) begin
              rdata <= load_ext;
            end
          end else if (tmo) begin
            err_q <= 1'b1;
            if (!we_q) rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: bus fields are presented only while requesting.
  always_comb begin
    bus_req_valid = (state == S_REQ);
    bus_addr      = bus_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_we        = bus_req_valid & we_q;
    bus_be        = bus_req_valid ? be_q : 4'b0000;
    bus_wdata     = bus_req_valid ? wdata_q : 32'h0;
    done          = (state == S_DONE);
    misalign      = done & misalign_q;
    err           = done & err_q;
  end

  // Stall follows req_valid combinationally and releases in DONE; forced low in reset.
  assign stall = rst & req_valid & (state != S_DONE);

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: per-feature tasks drive the core
// request and a scripted bus slave; expected completions are queued when a
// request is issued and compared when done pulses.
module tb_lsu_bus_bridge;

  localparam int TP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        bus_rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        misalign;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_mon;
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  lsu_bus_bridge #(.TIMEOUT(TP)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_func3    (req_func3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .misalign     (misalign),
    .err          (err),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data (bus_rsp_data),
    .bus_rsp_err  (bus_rsp_err)
  );

  always #5 clk = ~clk;

  // Reference byte-enable pattern.
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'd0: case (a[1:0])
              2'd0: return 4'b0001;
              2'd1: return 4'b0010;
              2'd2: return 4'b0100;
              default: return 4'b1000;
            endcase
      2'd1: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference lane-replicated store data.
  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'd0: return {w[7:0], w[7:0], w[7:0], w[7:0]};
      2'd1: return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  // Reference load extension.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a[1:0] +: 8];
    h = d[16*a[1] +: 16];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no access outstanding (rdata=%h)", rdata);
      end else begin
        exp_mon = sb.pop_front();
        if (rdata !== exp_mon.rdata || misalign !== exp_mon.misalign || err !== exp_mon.err) begin
          n_fail++;
          $display("FAIL completion: rdata=%h misalign=%b err=%b, expected rdata=%h misalign=%b err=%b",
                   rdata, misalign, err, exp_mon.rdata, exp_mon.misalign, exp_mon.err);
        end
      end
    end
  end

  // One complete core access with a scripted bus slave (ready after ready_dly
  // REQ cycles, response the cycle after acceptance). Starts and ends in IDLE.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ready_dly,
                        input logic [31:0] rsp_word, input logic rsp_e, input string name);
    exp_t e;
    logic ill, mis, tmo, accepted, got;
    int   lat, exp_reqc, cyc, reqc;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = !ill && ((f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0));
    tmo = !ill && !mis && (ready_dly >= TP);
    if (ill || mis) begin lat = 2;      exp_reqc = 0;             end
    else if (tmo)   begin lat = 2 + TP; exp_reqc = TP;            end
    else            begin lat = 4 + ready_dly; exp_reqc = ready_dly + 1; end
    e.misalign = mis;
    e.err      = ill || tmo || (!mis && rsp_e);
    if (ill || mis)  e.rdata = last_rdata;
    else if (tmo)    e.rdata = we ? last_rdata : 32'h0;
    else if (rsp_e)  e.rdata = 32'h0;
    else if (we)     e.rdata = last_rdata;
    else             e.rdata = ref_load(f3, addr, rsp_word);
    last_rdata = e.rdata;
    sb.push_back(e);

    req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stall_first_cycle: stall=%b expected 1", name, stall);
    end
    cyc = 1; reqc = 0; accepted = 1'b0; got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      if (accepted) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = rsp_word;
        bus_rsp_err   = rsp_e;
        accepted      = 1'b0;
      end
      n_checks++;
      if (done === 1'b1) begin
        got = 1'b1;
        if (stall !== 1'b0 || cyc != lat) begin
          n_fail++;
          $display("FAIL %s done_timing: done in cycle %0d stall=%b, expected cycle %0d stall=0",
                   name, cyc, stall, lat);
        end
      end else if (stall !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stall: stall=%b in cycle %0d, expected 1", name, stall, cyc);
      end
      if (bus_req_valid === 1'b1) begin
        reqc++;
        n_checks++;
        if (bus_addr !== {addr[31:2], 2'b00} || bus_be !== ref_be(f3, addr) || bus_we !== we ||
            (we && bus_wdata !== ref_wdata(f3, wdata))) begin
          n_fail++;
          $display("FAIL %s bus_fields: addr=%h be=%b we=%b wdata=%h, expected addr=%h be=%b we=%b wdata=%h",
                   name, bus_addr, bus_be, bus_we, bus_wdata, {addr[31:2], 2'b00},
                   ref_be(f3, addr), we, ref_wdata(f3, wdata));
        end
        bus_req_ready = (reqc > ready_dly);
        accepted      = bus_req_ready;
      end else begin
        bus_req_ready = 1'b0;
      end
    end
    n_checks++;
    if (!got || reqc != exp_reqc) begin
      n_fail++;
      $display("FAIL %s bus_request_cycles: done_seen=%b req_cycles=%0d, expected done_seen=1 req_cycles=%0d",
               name, got, reqc, exp_reqc);
    end
    if (!got) void'(sb.pop_back());
    req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_req_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: bus_req_valid=%b done=%b, expected 0 0", name, bus_req_valid, done);
    end
  endtask

  // Every output must read zero.
  task automatic check_all_zero(input string name);
    n_checks++;
    if ({stall, done, rdata, misalign, err, bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs_zero: stall=%b done=%b rdata=%h misalign=%b err=%b brv=%b baddr=%h bwe=%b bbe=%b bwdata=%h, expected all 0",
               name, stall, done, rdata, misalign, err, bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0; req_addr = '0; req_wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_lw();
    access(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, "lw_0x100");
  endtask

  task automatic test_byte_loads();
    access(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b0, "lb_0x103");
    access(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b0, "lbu_0x103");
    access(1'b0, 3'd0, 32'h101, 32'h0, 1, 32'h80FF1234, 1'b0, "lb_0x101");
  endtask

  task automatic test_half_loads();
    access(1'b0, 3'd1, 32'h102, 32'h0, 0, 32'h80017FFF, 1'b0, "lh_0x102");
    access(1'b0, 3'd5, 32'h102, 32'h0, 0, 32'h80017FFF, 1'b0, "lhu_0x102");
    access(1'b0, 3'd1, 32'h100, 32'h0, 0, 32'h8001F00F, 1'b0, "lh_0x100");
  endtask

  task automatic test_stores();
    access(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 3, 32'h0, 1'b0, "sh_0x202_delayed");
    access(1'b1, 3'd0, 32'h205, 32'h11223344, 0, 32'h0, 1'b0, "sb_0x205");
    access(1'b1, 3'd2, 32'h208, 32'hCAFEF00D, 2, 32'h0, 1'b0, "sw_0x208");
  endtask

  task automatic test_misaligned();
    access(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0, 1'b0, "lw_misaligned");
    access(1'b0, 3'd1, 32'h103, 32'h0, 0, 32'h0, 1'b0, "lh_misaligned");
    access(1'b1, 3'd2, 32'h20E, 32'h5, 0, 32'h0, 1'b0, "sw_misaligned");
  endtask

  task automatic test_bus_error();
    access(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'h12345678, 1'b1, "lw_bus_error");
  endtask

  task automatic test_illegal();
    access(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 1'b0, "load_f3_011");
    access(1'b1, 3'd4, 32'h100, 32'h0, 0, 32'h0, 1'b0, "store_f3_100");
  endtask

  task automatic test_timeout();
    access(1'b0, 3'd2, 32'h200, 32'h0, 0, 32'hA5A5A5A5, 1'b0, "lw_before_timeout");
    access(1'b0, 3'd2, 32'h400, 32'h0, 1000, 32'h0, 1'b0, "lw_timeout");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 3'd2, 32'h600 + 32'(4 * i), 32'h0, i % 2, 32'h01020304 * 32'(i + 1), 1'b0,
             "lw_back_to_back");
    end
  endtask

  task automatic test_reset_mid_rsp();
    req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h300; req_wdata = '0; req_valid = 1'b1;
    @(negedge clk);                 // REQ
    bus_req_ready = 1'b1;
    @(negedge clk);                 // RSP
    bus_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_rsp");
    last_rdata = 32'h0;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h12345678; bus_rsp_err = 1'b0;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("late_rsp_ignored");
    access(1'b0, 3'd2, 32'h304, 32'h0, 0, 32'h0BADF00D, 1'b0, "lw_after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_half_loads();
    test_stores();
    test_misaligned();
    test_bus_error();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid_rsp();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
